// File: rtl/leg_alu_pkg.sv
// Shared constants for the LEG ALU shift path: op codes, data width,
// per-cycle shift limit and the sequencer state encoding.
package leg_alu_pkg;

  localparam int WIDTH    = 8;
  localparam int MAX_STEP = 4;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/leg_shift_step.sv
// Combinational shift of an 8-bit operand by 0..4 positions for LSL/LSR/ASR/ROR,
// returning the last bit shifted out (step 0 passes the operand with carry 0).
module leg_shift_step
  import leg_alu_pkg::*;
(
  input  logic [1:0]       op,
  input  logic [7:0]       din,
  input  logic [2:0]       step,
  output logic [7:0]       dout,
  output logic             carry_out
);

  logic [8:0]  lsl_ext;
  logic [8:0]  lsr_ext;
  logic [8:0]  asr_ext;
  logic [15:0] ror_ext;

  // One guard bit on the exit side catches the last bit shifted out.
  always_comb begin
    lsl_ext = {1'b0, din} << step;
    lsr_ext = {din, 1'b0} >> step;
    asr_ext = 9'($signed({din, 1'b0}) >>> step);
    ror_ext = {din, din} >> step;
  end

  always_comb begin
    dout      = din;
    carry_out = 1'b0;
    case (op)
      SHIFT_LSL: begin
        dout      = lsl_ext[7:0];
        carry_out = lsl_ext[8];
      end
      SHIFT_LSR: begin
        dout      = lsr_ext[8:1];
        carry_out = lsr_ext[0];
      end
      SHIFT_ASR: begin
        dout      = asr_ext[8:1];
        carry_out = asr_ext[0];
      end
      default: begin
        dout      = ror_ext[7:0];
        carry_out = ror_ext[7];
      end
    endcase
    if (step == 3'd0) begin
      dout      = din;
      carry_out = 1'b0;
    end
  end

endmodule

// File: rtl/leg_shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: splits an 8-bit shift count into steps
// of at most four positions and hands back result, carry and zero flags.
//
//   state | meaning
//   IDLE  | ready for a request; in_ready high
//   SHIFT | applying one step of up to MAX_STEP positions per clock
//   DONE  | result held with out_valid until out_ready
module leg_shift_sequencer
  import leg_alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] value,
  input  logic [7:0]       amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] rem_q, rem_d;
  logic       carry_q, carry_d;
  logic [1:0] op_q, op_d;

  logic [3:0] eff;
  logic [2:0] step;
  logic [7:0] step_res;
  logic       step_carry;

  // Rotates wrap modulo 8; plain shifts saturate at 8 (everything shifted out).
  always_comb begin
    if (op == SHIFT_ROR)
      eff = {1'b0, amount[2:0]};
    else if (amount > 8'd8)
      eff = 4'd8;
    else
      eff = amount[3:0];
  end

  always_comb begin
    if (rem_q > 4'(MAX_STEP))
      step = 3'(MAX_STEP);
    else
      step = rem_q[2:0];
  end

  leg_shift_step u_step (
    .op        (op_q),
    .din       (acc_q),
    .step      (step),
    .dout      (step_res),
    .carry_out (step_carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    carry_d = carry_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op;
          acc_d   = value;
          rem_d   = eff;
          carry_d = 1'b0;
          state_d = (eff == 4'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = step_res;
        rem_d   = rem_q - {1'b0, step};
        carry_d = step_carry;
        if (rem_q == {1'b0, step})
          state_d = DONE;
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 8'h00;
      rem_q   <= 4'd0;
      carry_q <= 1'b0;
      op_q    <= SHIFT_LSL;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
      op_q    <= op_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = acc_q;
  assign carry     = carry_q;
  // Gated so the flag reads 0 out of reset even though acc is 0 there.
  assign zero      = out_valid && (acc_q == 8'h00);

endmodule

// File: tb/tb_leg_shift_sequencer.sv
// Directed test of leg_shift_sequencer with hand-computed results, flags and latencies.
module tb_leg_shift_sequencer;
  import leg_alu_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [7:0] value;
  logic [7:0] amount;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
  logic       zero;

  int errors = 0;
  int checks = 0;

  leg_shift_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .value     (value),
    .amount    (amount),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure edges to out_valid, check outputs, optionally
  // stall the consumer for hold cycles, then release the result.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [7:0] v,
                        input logic [7:0] a, input logic [7:0] er, input logic ec,
                        input logic ez, input int el, input int hold);
    int n;
    @(negedge clk);
    check({nm, ".in_ready_pre"}, {15'd0, in_ready}, 16'd1);
    in_valid = 1'b1;
    op       = o;
    value    = v;
    amount   = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({nm, ".out_valid"}, {15'd0, out_valid}, 16'd1);
    check({nm, ".latency"}, 16'(n), 16'(el));
    check({nm, ".result"}, {8'd0, result}, {8'd0, er});
    check({nm, ".carry"}, {15'd0, carry}, {15'd0, ec});
    check({nm, ".zero"}, {15'd0, zero}, {15'd0, ez});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({nm, ".hold_valid"}, {15'd0, out_valid}, 16'd1);
      check({nm, ".hold_result"}, {8'd0, result}, {8'd0, er});
      check({nm, ".hold_carry"}, {15'd0, carry}, {15'd0, ec});
      check({nm, ".hold_in_ready"}, {15'd0, in_ready}, 16'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({nm, ".released"}, {15'd0, out_valid}, 16'd0);
    check({nm, ".in_ready_post"}, {15'd0, in_ready}, 16'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    op        = SHIFT_LSL;
    value     = 8'h55;
    amount    = 8'd1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", {15'd0, in_ready}, 16'd1);
    check("rst.out_valid", {15'd0, out_valid}, 16'd0);
    check("rst.result", {8'd0, result}, 16'h0000);
    check("rst.carry", {15'd0, carry}, 16'd0);
    check("rst.zero", {15'd0, zero}, 16'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_op("lsl3",   SHIFT_LSL, 8'h35, 8'd3,  8'hA8, 1'b1, 1'b0, 2, 0);
    run_op("lsr5",   SHIFT_LSR, 8'h81, 8'd5,  8'h04, 1'b0, 1'b0, 3, 0);
    run_op("asr9",   SHIFT_ASR, 8'h80, 8'd9,  8'hFF, 1'b1, 1'b0, 3, 0);
    run_op("lsl8",   SHIFT_LSL, 8'h35, 8'd8,  8'h00, 1'b1, 1'b1, 3, 0);
    run_op("ror10",  SHIFT_ROR, 8'h01, 8'd10, 8'h40, 1'b0, 1'b0, 2, 0);
    run_op("ror8",   SHIFT_ROR, 8'h96, 8'd8,  8'h96, 1'b0, 1'b0, 1, 0);
    run_op("ror3",   SHIFT_ROR, 8'h81, 8'd3,  8'h30, 1'b0, 1'b0, 2, 0);
    run_op("asr2",   SHIFT_ASR, 8'h86, 8'd2,  8'hE1, 1'b1, 1'b0, 2, 0);
    run_op("lsl0",   SHIFT_LSL, 8'h00, 8'd0,  8'h00, 1'b0, 1'b1, 1, 3);

    // Abort mid-shift with reset.
    @(negedge clk);
    in_valid = 1'b1;
    op       = SHIFT_LSR;
    value    = 8'hFF;
    amount   = 8'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("abort.in_shift", {15'd0, in_ready}, 16'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort.out_valid", {15'd0, out_valid}, 16'd0);
    check("abort.in_ready", {15'd0, in_ready}, 16'd1);
    check("abort.result", {8'd0, result}, 16'h0000);
    @(posedge clk);
    #1;
    check("abort.no_output", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_abort", SHIFT_LSL, 8'h01, 8'd1, 8'h02, 1'b0, 1'b0, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
